// File: rtl/gaussian_3x3.sv
// Two-stage 3x3 Gaussian blur [1 2 1; 2 4 2; 1 2 1]/16 for one pixel per strobe.
// Define GAUSS_ROUND_EN to round to nearest instead of truncating.
module gaussian_3x3 #(
    parameter int WIDTH = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [3*WIDTH-1:0] r0_data_in,
    input  logic [3*WIDTH-1:0] r1_data_in,
    input  logic [3*WIDTH-1:0] r2_data_in,
    input  logic               data_valid_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               data_valid_out,
    output logic               error_out,
    output logic               busy_out
);

    localparam int SW = WIDTH + 4;

    logic [8:0][WIDTH-1:0] pix_q, pix_d;
    logic [SW-1:0]         sum_q, sum_d;
    logic [WIDTH-1:0]      out_q, out_d;
    logic                  v1_q, v1_d;
    logic                  v2_q, v2_d;
    logic                  dv_q, dv_d;
    logic                  err_q, err_d;

    logic                  busy;
    logic                  accept;
    logic [SW-1:0]         corner;
    logic [SW-1:0]         edge_sum;
    logic [SW-1:0]         centre;
    logic [SW-1:0]         weighted;
    logic [SW-1:0]         scaled;

    assign busy   = v1_q | v2_q;
    assign accept = data_valid_in & ~busy;

    // pix index = 3*row + column, column 0 = left (top slice of the row)
    always_comb begin
        corner   = SW'(pix_q[0]) + SW'(pix_q[2])
                 + SW'(pix_q[6]) + SW'(pix_q[8]);
        edge_sum = SW'(pix_q[1]) + SW'(pix_q[3])
                 + SW'(pix_q[5]) + SW'(pix_q[7]);
        centre   = SW'(pix_q[4]);
        weighted = corner + (edge_sum << 1) + (centre << 2);
    end

`ifdef GAUSS_ROUND_EN
    assign scaled = (sum_q + SW'(8)) >> 4;
`else
    assign scaled = sum_q >> 4;
`endif

    always_comb begin
        pix_d = pix_q;
        sum_d = sum_q;
        out_d = out_q;
        v1_d  = accept;
        v2_d  = v1_q;
        dv_d  = v2_q;
        err_d = data_valid_in & busy;

        if (accept) begin
            for (int c = 0; c < 3; c++) begin
                pix_d[c]     = r0_data_in[(2-c)*WIDTH +: WIDTH];
                pix_d[3 + c] = r1_data_in[(2-c)*WIDTH +: WIDTH];
                pix_d[6 + c] = r2_data_in[(2-c)*WIDTH +: WIDTH];
            end
        end

        if (v1_q) begin
            sum_d = weighted;
        end

        if (v2_q) begin
            out_d = WIDTH'(scaled);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pix_q <= '0;
            sum_q <= '0;
            out_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            dv_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pix_q <= pix_d;
            sum_q <= sum_d;
            out_q <= out_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            dv_q  <= dv_d;
            err_q <= err_d;
        end
    end

    assign data_out       = out_q;
    assign data_valid_out = dv_q;
    assign error_out      = err_q;
    assign busy_out       = busy;

endmodule

// File: tb/tb_gaussian_3x3.sv
// Randomised and directed bench for gaussian_3x3 against a kernel-sum model.
// Build with GAUSS_ROUND_EN defined to check the rounding variant.
module tb_gaussian_3x3;

    localparam int W = 8;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [3*W-1:0]   r0, r1, r2;
    logic             dv_in;
    logic [W-1:0]     data_out;
    logic             dv_out;
    logic             err_out;
    logic             busy_out;

    int checks   = 0;
    int failures = 0;

    gaussian_3x3 #(.WIDTH(W)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .r0_data_in    (r0),
        .r1_data_in    (r1),
        .r2_data_in    (r2),
        .data_valid_in (dv_in),
        .data_out      (data_out),
        .data_valid_out(dv_out),
        .error_out     (err_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model(logic [3*W-1:0] a, logic [3*W-1:0] b,
                                 logic [3*W-1:0] c);
        int k [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
        logic [3*W-1:0] rows [3];
        int s = 0;
        rows[0] = a;
        rows[1] = b;
        rows[2] = c;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += k[i][j] * int'(rows[i][(2-j)*W +: W]);
`ifdef GAUSS_ROUND_EN
        return (s + 8) / 16;
`else
        return s / 16;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic scramble();
        r0 = 24'($urandom);
        r1 = 24'($urandom);
        r2 = 24'($urandom);
    endtask

    task automatic run_one(string tag, logic [3*W-1:0] a,
                           logic [3*W-1:0] b, logic [3*W-1:0] c,
                           int exp, bit inj);
        r0 = a;
        r1 = b;
        r2 = c;
        dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
        scramble();
        check({tag, "_busy1"}, busy_out, 1);
        check({tag, "_dv1"}, dv_out, 0);
        check({tag, "_err1"}, err_out, 0);
        if (inj) dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
        scramble();
        check({tag, "_busy2"}, busy_out, 1);
        check({tag, "_dv2"}, dv_out, 0);
        check({tag, "_err2"}, err_out, 32'(inj));
        tick();
        check({tag, "_dv3"}, dv_out, 1);
        check({tag, "_data"}, data_out, exp);
        check({tag, "_busy3"}, busy_out, 0);
        check({tag, "_err3"}, err_out, 0);
        tick();
        check({tag, "_dv4"}, dv_out, 0);
        check({tag, "_hold"}, data_out, exp);
    endtask

    initial begin
        logic [3*W-1:0] a, b, c;
        int exp_c, exp_tl, exp_tc, exp_b2b;

`ifdef GAUSS_ROUND_EN
        exp_c  = 64;
        exp_tl = 16;
        exp_tc = 32;
`else
        exp_c  = 63;
        exp_tl = 15;
        exp_tc = 31;
`endif

        rst_in = 1'b0;
        dv_in  = 1'b0;
        r0 = '0;
        r1 = '0;
        r2 = '0;
        tick();
        tick();
        check("rst_data", data_out, 0);
        check("rst_dv", dv_out, 0);
        check("rst_err", err_out, 0);
        check("rst_busy", busy_out, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();

        run_one("uniform", {3{8'd100}}, {3{8'd100}}, {3{8'd100}}, 100, 0);
        run_one("centre", 24'h0, 24'h00FF00, 24'h0, exp_c, 0);
        run_one("topleft", 24'hFF0000, 24'h0, 24'h0, exp_tl, 0);
        run_one("topctr", 24'h00FF00, 24'h0, 24'h0, exp_tc, 0);
        run_one("all255", 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 255, 0);
        run_one("packing", 24'h0, 24'h0000A0, 24'h0, 20, 0);

        // back-to-back strobes: second is dropped, first result survives
        a = 24'h102030;
        b = 24'h405060;
        c = 24'h708090;
        exp_b2b = model(a, b, c);
        r0 = a;
        r1 = b;
        r2 = c;
        dv_in = 1'b1;
        tick();
        scramble();
        tick();
        dv_in = 1'b0;
        check("b2b_err", err_out, 1);
        check("b2b_dv_early", dv_out, 0);
        tick();
        check("b2b_dv", dv_out, 1);
        check("b2b_data", data_out, exp_b2b);
        check("b2b_err_once", err_out, 0);
        a = 24'($urandom);
        b = 24'($urandom);
        c = 24'($urandom);
        run_one("b2b_next", a, b, c, model(a, b, c), 0);

        // reset while a result is in flight
        r0 = 24'hFFFFFF;
        r1 = 24'hFFFFFF;
        r2 = 24'hFFFFFF;
        dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
        rst_in = 1'b0;
        #1;
        check("mid_rst_data", data_out, 0);
        check("mid_rst_busy", busy_out, 0);
        check("mid_rst_dv", dv_out, 0);
        tick();
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_dv", dv_out, 0);
            check("post_rst_data", data_out, 0);
        end
        run_one("post_rst", 24'h0, 24'h0000A0, 24'h0, 20, 0);

        for (int n = 0; n < 40; n++) begin
            a = 24'($urandom);
            b = 24'($urandom);
            c = 24'($urandom);
            run_one("rand", a, b, c, model(a, b, c), 1'($urandom_range(0, 1)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                check("gap_dv", dv_out, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
